// File: rtl/control_state_monitor_if.sv
// Bundle between the Control FSM (master drives state/opcode) and its monitor (slave reports).
// STATE_MON_PERF_EN adds the total_cycles / stall_events performance counters.
interface control_state_monitor_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       state;
  logic [5:0]       opcode;
  logic             retire;
  logic [2:0]       retire_class;
  logic [5:0]       retire_opcode;
  logic [3:0]       retire_cycles;
  logic [CNT_W-1:0] retire_count;
  logic             illegal;
  logic             error_sticky;
  logic [3:0]       err_prev_state;
  logic [3:0]       err_state;
`ifdef STATE_MON_PERF_EN
  logic [CNT_W-1:0] total_cycles;
  logic [CNT_W-1:0] stall_events;

  modport master (
    output state, opcode,
    input  retire, retire_class, retire_opcode, retire_cycles, retire_count,
    input  illegal, error_sticky, err_prev_state, err_state, total_cycles, stall_events
  );
  modport slave (
    input  state, opcode,
    output retire, retire_class, retire_opcode, retire_cycles, retire_count,
    output illegal, error_sticky, err_prev_state, err_state, total_cycles, stall_events
  );
`else
  modport master (
    output state, opcode,
    input  retire, retire_class, retire_opcode, retire_cycles, retire_count,
    input  illegal, error_sticky, err_prev_state, err_state
  );
  modport slave (
    input  state, opcode,
    output retire, retire_class, retire_opcode, retire_cycles, retire_count,
    output illegal, error_sticky, err_prev_state, err_state
  );
`endif
endinterface

// File: rtl/control_state_monitor.sv
// Passive monitor of the multicycle Control FSM: reports retirements and illegal transitions.
// Optional macro STATE_MON_PERF_EN enables total_cycles and stall_events counters.
module control_state_monitor #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  control_state_monitor_if.slave mon
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,  S_RF   = 4'd1,  S_IMM3 = 4'd2, S_ALUR3 = 4'd3,
    S_ALURI3 = 4'd4,  S_ALU4 = 4'd5,  S_BR3  = 4'd6, S_MEM3  = 4'd7,
    S_LD4    = 4'd8,  S_ST4  = 4'd9,  S_LD5  = 4'd10, S_J3   = 4'd11
  } state_e;

  localparam logic [2:0] C_R = 3'd0, C_RI = 3'd1, C_BR = 3'd2, C_LD = 3'd3,
                         C_ST = 3'd4, C_J = 3'd5, C_LDI = 3'd6;

  function automatic logic legal_edge(input logic [3:0] prv, input logic [3:0] nxt);
    logic ok;
    ok = 1'b0;
    case (prv)
      S_IF:            ok = (nxt == S_RF) || (nxt == S_IMM3);
      S_RF:            ok = (nxt == S_IMM3) || (nxt == S_ALUR3) || (nxt == S_ALURI3) ||
                            (nxt == S_BR3) || (nxt == S_MEM3) || (nxt == S_J3);
      S_ALUR3,
      S_ALURI3:        ok = (nxt == S_ALU4);
      S_MEM3:          ok = (nxt == S_LD4) || (nxt == S_ST4);
      S_LD4:           ok = (nxt == S_LD5);
      S_IMM3, S_ALU4, S_BR3,
      S_ST4, S_LD5, S_J3: ok = (nxt == S_IF);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] term_class(input logic [3:0] prv, input logic ri);
    logic [2:0] c;
    c = C_R;
    case (prv)
      S_ALU4:  c = ri ? C_RI : C_R;
      S_BR3:   c = C_BR;
      S_LD5:   c = C_LD;
      S_ST4:   c = C_ST;
      S_J3:    c = C_J;
      S_IMM3:  c = C_LDI;
      default: c = C_R;
    endcase
    return c;
  endfunction

`ifdef STATE_MON_PERF_EN
  // LDI is held to the longer RF path so the IMM3 shortcut never counts as a stall.
  function automatic logic [3:0] expected_cycles(input logic [2:0] cls);
    logic [3:0] e;
    case (cls)
      C_R, C_RI, C_ST: e = 4'd4;
      C_BR, C_J, C_LDI: e = 4'd3;
      C_LD:            e = 4'd5;
      default:         e = 4'd15;
    endcase
    return e;
  endfunction
`endif

  logic [3:0]       r_prev_state;
  logic             r_prev_valid;
  logic [3:0]       r_cyc;
  logic             r_track;
  logic             r_ri;
  logic [5:0]       r_op;
  logic             r_retire;
  logic [2:0]       r_class;
  logic [5:0]       r_ret_op;
  logic [3:0]       r_ret_cyc;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;
  logic             r_sticky;
  logic [3:0]       r_err_prev;
  logic [3:0]       r_err_state;
`ifdef STATE_MON_PERF_EN
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_stall;
`endif

  logic [3:0] w_state;
  logic       w_illegal;
  logic       w_retire;
  logic [2:0] w_class;

  // Stage p0: classify the edge from the previous sample to the current one
  assign w_state   = mon.state;
  assign w_illegal = r_prev_valid && !legal_edge(r_prev_state, w_state);
  assign w_retire  = r_prev_valid && !w_illegal && (w_state == S_IF) && r_track;
  assign w_class   = term_class(r_prev_state, r_ri);

  // Stage p1: registered reporting; r_track gates retirement until an IF is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_state <= S_IF;
      r_prev_valid <= 1'b0;
      r_cyc        <= 4'd0;
      r_track      <= 1'b0;
      r_ri         <= 1'b0;
      r_op         <= 6'd0;
      r_retire     <= 1'b0;
      r_class      <= 3'd0;
      r_ret_op     <= 6'd0;
      r_ret_cyc    <= 4'd0;
      r_count      <= '0;
      r_illegal    <= 1'b0;
      r_sticky     <= 1'b0;
      r_err_prev   <= 4'd0;
      r_err_state  <= 4'd0;
`ifdef STATE_MON_PERF_EN
      r_total      <= '0;
      r_stall      <= '0;
`endif
    end else begin
      r_prev_state <= w_state;
      r_prev_valid <= 1'b1;
      if (w_state == S_IF)
        r_cyc <= 4'd1;
      else if (r_cyc != 4'd15)
        r_cyc <= r_cyc + 4'd1;
      if ((w_state == S_ALUR3) || (w_state == S_ALURI3))
        r_ri <= (w_state == S_ALURI3);
      if (r_prev_valid && (r_prev_state == S_IF) && (w_state != S_IF))
        r_op <= mon.opcode;
      if (w_state == S_IF)
        r_track <= 1'b1;
      else if (w_illegal)
        r_track <= 1'b0;
      r_retire  <= w_retire;
      r_illegal <= w_illegal;
      if (w_retire) begin
        r_class   <= w_class;
        r_ret_op  <= r_op;
        r_ret_cyc <= r_cyc;
        r_count   <= r_count + CNT_W'(1);
      end
      if (w_illegal && !r_sticky) begin
        r_sticky    <= 1'b1;
        r_err_prev  <= r_prev_state;
        r_err_state <= w_state;
      end
`ifdef STATE_MON_PERF_EN
      r_total <= r_total + CNT_W'(1);
      if (w_retire && (r_cyc > expected_cycles(w_class)))
        r_stall <= r_stall + CNT_W'(1);
`endif
    end
  end

  assign mon.retire         = r_retire;
  assign mon.retire_class   = r_class;
  assign mon.retire_opcode  = r_ret_op;
  assign mon.retire_cycles  = r_ret_cyc;
  assign mon.retire_count   = r_count;
  assign mon.illegal        = r_illegal;
  assign mon.error_sticky   = r_sticky;
  assign mon.err_prev_state = r_err_prev;
  assign mon.err_state      = r_err_state;
`ifdef STATE_MON_PERF_EN
  assign mon.total_cycles   = r_total;
  assign mon.stall_events   = r_stall;
`endif

endmodule

// File: tb/tb_control_state_monitor.sv
// Scoreboard bench for control_state_monitor: directed instruction streams plus random walks.
module tb_control_state_monitor;
  localparam int CNT_W = 4;
  localparam int ADD = 6'h20, ADDI = 6'h08, BEQ = 6'h04, LDOP = 6'h23;
  localparam int STR = 6'h2B, JUMP = 6'h02, LDI = 6'h0F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_state_monitor_if #(.CNT_W(CNT_W)) bus ();
  control_state_monitor #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .mon(bus));

  typedef struct packed {
    logic             ret;
    logic             ill;
    logic [2:0]       cls;
    logic [5:0]       op;
    logic [3:0]       cyc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;
    logic [3:0]       ep;
    logic [3:0]       es;
`ifdef STATE_MON_PERF_EN
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] stall;
`endif
  } obs_t;

  obs_t exp_q[$];
  int errors = 0;
  int checks = 0;
  bit [15:0] succ [16];
  int exp_c [7] = '{4, 4, 3, 5, 4, 3, 3};
  int cyc_tab [7] = '{4, 4, 3, 5, 4, 3, 2};

  // reference model: instruction path as a list of visited states
  bit               m_pv, m_track, m_sticky;
  int               m_prev;
  int               m_path[$];
  logic [5:0]       m_op, m_rop;
  logic [2:0]       m_rcls;
  logic [3:0]       m_rcyc, m_ep, m_es;
  logic [CNT_W-1:0] m_cnt, m_total, m_stall;

  function automatic obs_t sample();
    obs_t o;
    o.ret = bus.retire;           o.ill = bus.illegal;
    o.cls = bus.retire_class;     o.op = bus.retire_opcode;
    o.cyc = bus.retire_cycles;    o.cnt = bus.retire_count;
    o.sticky = bus.error_sticky;  o.ep = bus.err_prev_state;
    o.es = bus.err_state;
`ifdef STATE_MON_PERF_EN
    o.total = bus.total_cycles;   o.stall = bus.stall_events;
`endif
    return o;
  endfunction

  function automatic obs_t model_obs(input bit ret, input bit ill);
    obs_t o;
    o.ret = ret;  o.ill = ill;  o.cls = m_rcls;  o.op = m_rop;  o.cyc = m_rcyc;
    o.cnt = m_cnt;  o.sticky = m_sticky;  o.ep = m_ep;  o.es = m_es;
`ifdef STATE_MON_PERF_EN
    o.total = m_total;  o.stall = m_stall;
`endif
    return o;
  endfunction

  function automatic logic [2:0] class_of();
    case (m_path[m_path.size()-1])
      2:       return 3'd6;
      5:       return (m_path[2] == 4) ? 3'd1 : 3'd0;
      6:       return 3'd2;
      10:      return 3'd3;
      9:       return 3'd4;
      11:      return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  task automatic model_reset();
    m_pv = 0; m_track = 0; m_sticky = 0; m_prev = 0; m_path.delete();
    m_op = '0; m_rop = '0; m_rcls = '0; m_rcyc = '0; m_ep = '0; m_es = '0;
    m_cnt = '0; m_total = '0; m_stall = '0;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step(input int st, input int op);
    bit ill, ret;
    bus.state = 4'(st);
    bus.opcode = 6'(op);
    m_total = m_total + 1'b1;
    ill = m_pv && !succ[m_prev][st];
    ret = m_pv && !ill && (st == 0) && m_track;
    if (ret) begin
      m_rcls = class_of();
      m_rop  = m_op;
      m_rcyc = (m_path.size() > 15) ? 4'd15 : 4'(m_path.size());
      m_cnt  = m_cnt + 1'b1;
      if (int'(m_rcyc) > exp_c[m_rcls]) m_stall = m_stall + 1'b1;
    end
    if (ill && !m_sticky) begin
      m_sticky = 1; m_ep = 4'(m_prev); m_es = 4'(st);
    end
    if (m_pv && m_prev == 0 && st != 0) m_op = 6'(op);
    if (st == 0) m_path = {0};
    else if (m_path.size() < 32) m_path.push_back(st);
    m_track = (st == 0) ? 1'b1 : (ill ? 1'b0 : m_track);
    m_prev = st;
    m_pv = 1;
    if (ret || ill) exp_q.push_back(model_obs(ret, ill));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n, input int st);
    obs_t zero;
    zero = '0;
    reset = 1'b1;
    repeat (n) begin
      bus.state = (st < 0) ? 4'($urandom_range(0, 15)) : 4'(st);
      bus.opcode = 6'($urandom_range(0, 63));
      @(posedge clk); #1;
    end
    checks++;
    if (sample() !== zero) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", sample(), zero);
    end
    reset = 1'b0;
    model_reset();
  endtask

  // path after IF, then the IF that retires it
  task automatic instr(input int kind, input int op);
    int p[$];
    case (kind)
      0: p = {1, 3, 5};
      1: p = {1, 4, 5};
      2: p = {1, 6};
      3: p = {1, 7, 8, 10};
      4: p = {1, 7, 9};
      5: p = {1, 11};
      default: p = {2};
    endcase
    foreach (p[k]) step(p[k], op);
    step(0, $urandom_range(0, 63));
    chk("instr_retire", int'(bus.retire), 1);
    chk("instr_class", int'(bus.retire_class), kind);
    chk("instr_opcode", int'(bus.retire_opcode), op);
    chk("instr_cycles", int'(bus.retire_cycles), cyc_tab[kind]);
  endtask

  always @(negedge clk) begin : monitor_p
    obs_t a, e;
    a = sample();
    if (a.ret || a.ill) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h want=none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard got=%h want=%h", a, e);
        end
      end
    end
  end

  initial begin
    int ops[7];
    ops = '{ADD, ADDI, BEQ, LDOP, STR, JUMP, LDI};
    foreach (succ[s]) succ[s] = '0;
    succ[0] = 16'h0006;
    succ[1] = (16'h1 << 2) | (16'h1 << 3) | (16'h1 << 4) | (16'h1 << 6) | (16'h1 << 7) | (16'h1 << 11);
    succ[3] = 16'h1 << 5;
    succ[4] = 16'h1 << 5;
    succ[7] = (16'h1 << 8) | (16'h1 << 9);
    succ[8] = 16'h1 << 10;
    foreach (succ[s]) if (s == 2 || s == 5 || s == 6 || s == 9 || s == 10 || s == 11) succ[s] = 16'h1;
    bus.state = 4'd0;
    bus.opcode = 6'd0;
    model_reset();

    do_reset(3, -1);
    chk("reset_no_retire", int'(bus.retire), 0);

    step(0, 0);
    instr(0, ADD);
    chk("add_count", int'(bus.retire_count), 1);

    do_reset(2, -1);
    step(0, 0);
    for (int k = 0; k < 7; k++) instr(k, ops[k]);
    chk("seq_count", int'(bus.retire_count), 7);
    chk("seq_sticky", int'(bus.error_sticky), 0);

    step(1, ADD);
    step(1, ADD);
    chk("self_loop_illegal", int'(bus.illegal), 1);
    chk("err_prev", int'(bus.err_prev_state), 1);
    chk("err_state", int'(bus.err_state), 1);
    chk("sticky_set", int'(bus.error_sticky), 1);
    step(0, 0);
    chk("rf_if_illegal", int'(bus.illegal), 1);
    chk("rf_if_no_retire", int'(bus.retire), 0);
    instr(4, STR);
    step(12, 0);
    chk("s12_illegal", int'(bus.illegal), 1);
    chk("err_prev_kept", int'(bus.err_prev_state), 1);
    chk("err_state_kept", int'(bus.err_state), 1);
    step(0, 0);

    step(1, LDOP);
    step(7, LDOP);
    step(8, LDOP);
    do_reset(2, 8);
    step(0, 0);
    instr(0, ADD);
    chk("reset_discard_count", int'(bus.retire_count), 1);

    do_reset(3, -1);
    step(0, 0);
    for (int k = 0; k < 16; k++) instr(3, LDOP);
    chk("wrap_count", int'(bus.retire_count), 0);
`ifdef STATE_MON_PERF_EN
    chk("ld_no_stall", int'(bus.stall_events), 0);
`endif

    do_reset(1, -1);
    step(0, 0);
    for (int i = 0; i < 800; i++) begin
      int nx;
      int cand[$];
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1 + $urandom_range(0, 2), -1);
        step(0, 0);
      end else begin
        if ($urandom_range(0, 11) == 0) nx = $urandom_range(0, 15);
        else begin
          cand.delete();
          for (int s = 0; s < 16; s++) if (succ[m_prev][s]) cand.push_back(s);
          nx = (cand.size() == 0) ? 0 : cand[$urandom_range(0, cand.size() - 1)];
        end
        step(nx, $urandom_range(0, 63));
      end
    end
    step(0, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
